// File: rtl/ex_stage_md.sv
// Execute stage: operand forwarding, single-cycle ALU, iterative MULT/DIV engine
// with HI/LO registers, and the EX/MEM pipeline register.
module ex_stage_md #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int SH_W   = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              ex_flush,
  input  logic [4:0]        ex_op,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [DATA_W-1:0] imm,
  input  logic              alu_src_b,
  input  logic [REG_W-1:0]  dst_reg,
  input  logic [1:0]        rs_fwd_sel,
  input  logic [1:0]        rt_fwd_sel,
  input  logic [DATA_W-1:0] mem_fwd_val,
  input  logic [DATA_W-1:0] wb_fwd_val,
  input  logic              wb_reg_write,
  input  logic              wb_mem_to_reg,
  input  logic              mem_read,
  input  logic              mem_write,
  output logic              ex_stall,
  output logic [REG_W-1:0]  ex_dst_reg,
  output logic              EX_MEM_valid,
  output logic              EX_MEM_wb_reg_write,
  output logic              EX_MEM_wb_mem_to_reg,
  output logic              EX_MEM_mem_read,
  output logic              EX_MEM_mem_write,
  output logic [DATA_W-1:0] EX_MEM_alu_result,
  output logic [DATA_W-1:0] EX_MEM_B_value,
  output logic [REG_W-1:0]  EX_MEM_dst_reg
);
  localparam int CNT_W = $clog2(DATA_W) + 1;

  localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd1, OP_AND = 5'd2, OP_OR = 5'd3,
                         OP_XOR = 5'd4, OP_NOR = 5'd5, OP_SLT = 5'd6, OP_SLTU = 5'd7,
                         OP_SLL = 5'd8, OP_SRL = 5'd9, OP_SRA = 5'd10, OP_MFHI = 5'd11,
                         OP_MFLO = 5'd12, OP_MULT = 5'd13, OP_MULTU = 5'd14,
                         OP_DIV = 5'd15, OP_DIVU = 5'd16, OP_MTHI = 5'd17, OP_MTLO = 5'd18;

  typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_e;

  function automatic logic [DATA_W-1:0] fwd_mux(input logic [1:0] sel,
      input logic [DATA_W-1:0] rf, input logic [DATA_W-1:0] mem, input logic [DATA_W-1:0] wb);
    case (sel)
      2'd0:    return rf;
      2'd1:    return mem;
      2'd2:    return wb;
      default: return '0;
    endcase
  endfunction

  md_state_e           state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0]   opnd_q, opnd_d;
  logic                div_q, div_d, negq_q, negq_d, negr_q, negr_d, dz_q, dz_d;
  logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic              ex_mem_valid_q, ex_mem_valid_d, ex_mem_rw_q, ex_mem_rw_d;
  logic              ex_mem_m2r_q, ex_mem_m2r_d, ex_mem_mr_q, ex_mem_mr_d;
  logic              ex_mem_mw_q, ex_mem_mw_d;
  logic [DATA_W-1:0] ex_mem_res_q, ex_mem_res_d, ex_mem_b_q, ex_mem_b_d;
  logic [REG_W-1:0]  ex_mem_dst_q, ex_mem_dst_d;

  logic [DATA_W-1:0]   a, b_value, alu_b, alu_res;
  logic [SH_W-1:0]     sh;
  logic                is_md, is_mt, md_signed, md_div, sa, sb, retire;
  logic [DATA_W:0]     mul_sum, rem_sh;
  logic [DATA_W-1:0]   div_diff, quo_fix, rem_fix;
  logic [2*DATA_W-1:0] mul_next, div_next, prod_fix;

  assign a          = fwd_mux(rs_fwd_sel, A, mem_fwd_val, wb_fwd_val);
  assign b_value    = fwd_mux(rt_fwd_sel, B, mem_fwd_val, wb_fwd_val);
  assign alu_b      = alu_src_b ? imm : b_value;
  assign sh         = a[SH_W-1:0];
  assign ex_dst_reg = dst_reg;

  assign is_md     = (ex_op == OP_MULT) | (ex_op == OP_MULTU) | (ex_op == OP_DIV) | (ex_op == OP_DIVU);
  assign is_mt     = (ex_op == OP_MTHI) | (ex_op == OP_MTLO);
  assign md_signed = (ex_op == OP_MULT) | (ex_op == OP_DIV);
  assign md_div    = (ex_op == OP_DIV) | (ex_op == OP_DIVU);
  assign sa        = md_signed & a[DATA_W-1];
  assign sb        = md_signed & b_value[DATA_W-1];

  // Stall covers the accept cycle plus every BUSY cycle; never during reset.
  assign ex_stall = rst & ((state_q == MD_BUSY) |
                           ((state_q == MD_IDLE) & id_valid & is_md & ~ex_flush));
  assign retire   = id_valid & ~ex_flush & ~ex_stall;

  // Shift-add multiply step: acc = {partial product, remaining multiplier bits}.
  assign mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + {1'b0, {DATA_W{acc_q[0]}} & opnd_q};
  assign mul_next = {mul_sum, acc_q[DATA_W-1:1]};

  // Restoring divide step: acc = {partial remainder, dividend bits / quotient bits}.
  assign rem_sh   = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
  assign div_diff = rem_sh[DATA_W-1:0] - opnd_q;
  assign div_next = (rem_sh >= {1'b0, opnd_q}) ? {div_diff, acc_q[DATA_W-2:0], 1'b1}
                                               : {rem_sh[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0};

  assign prod_fix = negq_q ? -acc_q : acc_q;
  assign quo_fix  = negq_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
  assign rem_fix  = negr_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];

  always_comb begin
    alu_res = '0;
    case (ex_op)
      OP_ADD:  alu_res = a + alu_b;
      OP_SUB:  alu_res = a - alu_b;
      OP_AND:  alu_res = a & alu_b;
      OP_OR:   alu_res = a | alu_b;
      OP_XOR:  alu_res = a ^ alu_b;
      OP_NOR:  alu_res = ~(a | alu_b);
      OP_SLT:  alu_res = DATA_W'($signed(a) < $signed(alu_b));
      OP_SLTU: alu_res = DATA_W'(a < alu_b);
      OP_SLL:  alu_res = b_value << sh;
      OP_SRL:  alu_res = b_value >> sh;
      OP_SRA:  alu_res = $signed(b_value) >>> sh;
      OP_MFHI: alu_res = hi_q;
      OP_MFLO: alu_res = lo_q;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    div_d   = div_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (ex_flush) begin
      state_d = MD_IDLE;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (id_valid && is_md) begin
            state_d = MD_BUSY;
            count_d = CNT_W'(DATA_W);
            div_d   = md_div;
            negq_d  = sa ^ sb;
            negr_d  = md_div ? sa : (sa ^ sb);
            dz_d    = md_div & (b_value == '0);
            // Multiply keeps the multiplier in acc; divide keeps the dividend there.
            acc_d   = {{DATA_W{1'b0}}, md_div ? (sa ? -a : a) : (sb ? -b_value : b_value)};
            opnd_d  = md_div ? (sb ? -b_value : b_value) : (sa ? -a : a);
          end else if (id_valid && ex_op == OP_MTHI) begin
            hi_d = a;
          end else if (id_valid && ex_op == OP_MTLO) begin
            lo_d = a;
          end
        end
        MD_BUSY: begin
          acc_d   = div_q ? div_next : mul_next;
          count_d = count_q - CNT_W'(1);
          if (count_q == CNT_W'(1)) state_d = MD_DONE;
        end
        MD_DONE: begin
          if (div_q) begin
            lo_d = dz_q ? '1 : quo_fix;
            hi_d = rem_fix;
          end else begin
            hi_d = prod_fix[2*DATA_W-1:DATA_W];
            lo_d = prod_fix[DATA_W-1:0];
          end
          state_d = MD_IDLE;
        end
        default: state_d = MD_IDLE;
      endcase
    end
  end

  always_comb begin
    ex_mem_valid_d = retire;
    ex_mem_rw_d    = retire & wb_reg_write & ~is_md & ~is_mt;
    ex_mem_m2r_d   = retire & wb_mem_to_reg;
    ex_mem_mr_d    = retire & mem_read;
    ex_mem_mw_d    = retire & mem_write;
    ex_mem_res_d   = retire ? alu_res : '0;
    ex_mem_b_d     = retire ? b_value : '0;
    ex_mem_dst_d   = retire ? dst_reg : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= MD_IDLE;
      count_q        <= '0;
      div_q          <= 1'b0;
      negq_q         <= 1'b0;
      negr_q         <= 1'b0;
      dz_q           <= 1'b0;
      hi_q           <= '0;
      lo_q           <= '0;
      ex_mem_valid_q <= 1'b0;
      ex_mem_rw_q    <= 1'b0;
      ex_mem_m2r_q   <= 1'b0;
      ex_mem_mr_q    <= 1'b0;
      ex_mem_mw_q    <= 1'b0;
      ex_mem_res_q   <= '0;
      ex_mem_b_q     <= '0;
      ex_mem_dst_q   <= '0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      div_q          <= div_d;
      negq_q         <= negq_d;
      negr_q         <= negr_d;
      dz_q           <= dz_d;
      hi_q           <= hi_d;
      lo_q           <= lo_d;
      ex_mem_valid_q <= ex_mem_valid_d;
      ex_mem_rw_q    <= ex_mem_rw_d;
      ex_mem_m2r_q   <= ex_mem_m2r_d;
      ex_mem_mr_q    <= ex_mem_mr_d;
      ex_mem_mw_q    <= ex_mem_mw_d;
      ex_mem_res_q   <= ex_mem_res_d;
      ex_mem_b_q     <= ex_mem_b_d;
      ex_mem_dst_q   <= ex_mem_dst_d;
    end
  end

  // Engine datapath is only meaningful between accept and DONE, so it needs no reset.
  always_ff @(posedge clk) begin
    acc_q  <= acc_d;
    opnd_q <= opnd_d;
  end

  assign EX_MEM_valid         = ex_mem_valid_q;
  assign EX_MEM_wb_reg_write  = ex_mem_rw_q;
  assign EX_MEM_wb_mem_to_reg = ex_mem_m2r_q;
  assign EX_MEM_mem_read      = ex_mem_mr_q;
  assign EX_MEM_mem_write     = ex_mem_mw_q;
  assign EX_MEM_alu_result    = ex_mem_res_q;
  assign EX_MEM_B_value       = ex_mem_b_q;
  assign EX_MEM_dst_reg       = ex_mem_dst_q;
endmodule

// File: tb/tb_ex_stage_md.sv
// Scoreboard bench for ex_stage_md: stimulus pushes expected retire entries,
// a negedge monitor pops and compares whenever EX_MEM_valid is high.
module tb_ex_stage_md;
  logic        clk = 1'b0;
  logic        rst, id_valid, ex_flush, alu_src_b;
  logic [4:0]  ex_op, dst_reg;
  logic [31:0] A, B, imm, mem_fwd_val, wb_fwd_val;
  logic [1:0]  rs_fwd_sel, rt_fwd_sel;
  logic        wb_reg_write, wb_mem_to_reg, mem_read, mem_write;
  logic        ex_stall;
  logic [4:0]  ex_dst_reg, EX_MEM_dst_reg;
  logic        EX_MEM_valid, EX_MEM_wb_reg_write, EX_MEM_wb_mem_to_reg, EX_MEM_mem_read, EX_MEM_mem_write;
  logic [31:0] EX_MEM_alu_result, EX_MEM_B_value;

  always #5 clk = ~clk;

  ex_stage_md #(.DATA_W(32), .REG_W(5)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .ex_flush(ex_flush), .ex_op(ex_op),
    .A(A), .B(B), .imm(imm), .alu_src_b(alu_src_b), .dst_reg(dst_reg),
    .rs_fwd_sel(rs_fwd_sel), .rt_fwd_sel(rt_fwd_sel),
    .mem_fwd_val(mem_fwd_val), .wb_fwd_val(wb_fwd_val),
    .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
    .mem_read(mem_read), .mem_write(mem_write),
    .ex_stall(ex_stall), .ex_dst_reg(ex_dst_reg),
    .EX_MEM_valid(EX_MEM_valid), .EX_MEM_wb_reg_write(EX_MEM_wb_reg_write),
    .EX_MEM_wb_mem_to_reg(EX_MEM_wb_mem_to_reg), .EX_MEM_mem_read(EX_MEM_mem_read),
    .EX_MEM_mem_write(EX_MEM_mem_write), .EX_MEM_alu_result(EX_MEM_alu_result),
    .EX_MEM_B_value(EX_MEM_B_value), .EX_MEM_dst_reg(EX_MEM_dst_reg)
  );

  typedef struct {
    string       name;
    logic [31:0] res;
    logic [4:0]  dst;
    logic        rw;
    logic        mw;
    logic        chk_b;
    logic [31:0] bval;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst === 1'b1 && EX_MEM_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_retire: got result 0x%0h, expected no retire", EX_MEM_alu_result);
      end else begin
        e = sbq.pop_front();
        check({e.name, "_result"}, EX_MEM_alu_result, e.res);
        check({e.name, "_dst"}, EX_MEM_dst_reg, e.dst);
        check({e.name, "_reg_write"}, EX_MEM_wb_reg_write, e.rw);
        check({e.name, "_mem_write"}, EX_MEM_mem_write, e.mw);
        if (e.chk_b) check({e.name, "_b_value"}, EX_MEM_B_value, e.bval);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; ex_flush = 0; ex_op = 0; A = 0; B = 0; imm = 0; alu_src_b = 0;
    dst_reg = 0; rs_fwd_sel = 0; rt_fwd_sel = 0; mem_fwd_val = 0; wb_fwd_val = 0;
    wb_reg_write = 0; wb_mem_to_reg = 0; mem_read = 0; mem_write = 0;
  endtask

  task automatic drive(input logic [4:0] op, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] iv, input logic srcb, input logic [4:0] dst,
                       input logic [1:0] rs_s, input logic [1:0] rt_s,
                       input logic [31:0] mv, input logic [31:0] wv, input logic rw, input logic mw);
    id_valid = 1; ex_flush = 0; ex_op = op; A = av; B = bv; imm = iv; alu_src_b = srcb;
    dst_reg = dst; rs_fwd_sel = rs_s; rt_fwd_sel = rt_s; mem_fwd_val = mv; wb_fwd_val = wv;
    wb_reg_write = rw; wb_mem_to_reg = 0; mem_read = 0; mem_write = mw;
  endtask

  task automatic push(input string name, input logic [31:0] res, input logic [4:0] dst,
                      input logic rw, input logic mw, input logic chk_b, input logic [31:0] bval);
    exp_t e;
    e.name = name; e.res = res; e.dst = dst; e.rw = rw; e.mw = mw; e.chk_b = chk_b; e.bval = bval;
    sbq.push_back(e);
  endtask

  // Plain register-file operands, result to r7 with reg_write requested.
  task automatic alu(input string name, input logic [4:0] op, input logic [31:0] av,
                     input logic [31:0] bv, input logic [31:0] exp_res);
    drive(op, av, bv, 32'd0, 1'b0, 5'd7, 2'd0, 2'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    push(name, exp_res, 5'd7, 1'b1, 1'b0, 1'b1, bv);
    step();
    idle();
  endtask

  // Issues an MD op, counts stalled cycles, and lets the DONE entry retire.
  task automatic run_md(input string name, input logic [4:0] op, input logic [31:0] av,
                        input logic [31:0] bv, input bit perturb, output int cnt);
    if (perturb) drive(op, 32'd0, 32'd0, 32'd0, 1'b0, 5'd9, 2'd1, 2'd1, av, 32'd0, 1'b1, 1'b0);
    else         drive(op, av, bv, 32'd0, 1'b0, 5'd9, 2'd0, 2'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    push(name, 32'd0, 5'd9, 1'b0, 1'b0, 1'b0, 32'd0);
    #1;
    cnt = 0;
    while (ex_stall === 1'b1 && cnt < 100) begin
      cnt++;
      step();
      if (perturb) mem_fwd_val = 32'd5;
    end
    step();
    idle();
  endtask

  int cnt;

  initial begin
    rst = 0;
    idle();
    id_valid = 1; ex_op = 5'd13;
    #3;
    check("reset_stall_gated", ex_stall, 1'b0);
    step();
    check("reset_valid", EX_MEM_valid, 1'b0);
    check("reset_result", EX_MEM_alu_result, 32'd0);
    idle();
    step();
    rst = 1;
    step();

    alu("mfhi_after_reset", 5'd11, 32'd0, 32'd0, 32'd0);

    drive(5'd0, 32'd1, 32'd0, 32'd0, 1'b0, 5'd3, 2'd1, 2'd2, 32'd5, 32'd9, 1'b1, 1'b0);
    push("fwd_add", 32'd14, 5'd3, 1'b1, 1'b0, 1'b1, 32'd9);
    #1;
    check("ex_dst_reg_comb", ex_dst_reg, 5'd3);
    step();
    idle();

    alu("sub_wrap", 5'd1, 32'd0, 32'd1, 32'hFFFF_FFFF);
    alu("nor", 5'd5, 32'd0, 32'd0, 32'hFFFF_FFFF);
    alu("sltu", 5'd7, 32'd1, 32'hFFFF_FFFF, 32'd1);
    alu("slt_false", 5'd6, 32'd1, 32'hFFFF_FFFF, 32'd0);
    alu("sll", 5'd8, 32'd31, 32'd1, 32'h8000_0000);
    alu("srl", 5'd9, 32'd4, 32'h8000_0000, 32'h0800_0000);
    alu("bad_op", 5'd19, 32'd3, 32'd4, 32'd0);

    drive(5'd3, 32'hF0, 32'h1234, 32'h0F, 1'b1, 5'd4, 2'd0, 2'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    push("or_imm", 32'hFF, 5'd4, 1'b1, 1'b0, 1'b1, 32'h1234);
    step(); idle();

    drive(5'd0, 32'd7, 32'd100, 32'd0, 1'b0, 5'd0, 2'd0, 2'd3, 32'd0, 32'd0, 1'b0, 1'b1);
    push("store_rt_zero", 32'd7, 5'd0, 1'b0, 1'b1, 1'b1, 32'd0);
    step(); idle();

    run_md("mult_retire", 5'd13, 32'hFFFF_FFFD, 32'd7, 1'b0, cnt);
    check("mult_stall_cycles", cnt, 33);
    alu("mult_lo", 5'd12, 32'd0, 32'd0, 32'hFFFF_FFEB);
    alu("mult_hi", 5'd11, 32'd0, 32'd0, 32'hFFFF_FFFF);

    run_md("div_retire", 5'd15, 32'hFFFF_FFF9, 32'd2, 1'b0, cnt);
    alu("div_lo", 5'd12, 32'd0, 32'd0, 32'hFFFF_FFFD);
    alu("div_hi", 5'd11, 32'd0, 32'd0, 32'hFFFF_FFFF);

    run_md("divu0_retire", 5'd16, 32'd7, 32'd0, 1'b0, cnt);
    alu("divu0_lo", 5'd12, 32'd0, 32'd0, 32'hFFFF_FFFF);
    alu("divu0_hi", 5'd11, 32'd0, 32'd0, 32'd7);

    run_md("divmin_retire", 5'd15, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, cnt);
    alu("divmin_lo", 5'd12, 32'd0, 32'd0, 32'h8000_0000);
    alu("divmin_hi", 5'd11, 32'd0, 32'd0, 32'd0);

    run_md("multu_retire", 5'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, cnt);
    check("multu_stall_cycles", cnt, 33);
    drive(5'd17, 32'h1234, 32'd0, 32'd0, 1'b0, 5'd6, 2'd0, 2'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    push("mthi_retire", 32'd0, 5'd6, 1'b0, 1'b0, 1'b0, 32'd0);
    step(); idle();
    alu("multu_lo", 5'd12, 32'd0, 32'd0, 32'd1);
    alu("mthi_hi", 5'd11, 32'd0, 32'd0, 32'h1234);

    drive(5'd15, 32'd100, 32'd7, 32'd0, 1'b0, 5'd9, 2'd0, 2'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    #1;
    repeat (10) step();
    check("flush_busy_stall", ex_stall, 1'b1);
    ex_flush = 1;
    step();
    idle();
    #1;
    check("flush_stall_low", ex_stall, 1'b0);
    check("flush_bubble", EX_MEM_valid, 1'b0);
    step();
    alu("flush_hi_kept", 5'd11, 32'd0, 32'd0, 32'h1234);
    alu("flush_lo_kept", 5'd12, 32'd0, 32'd0, 32'd1);

    drive(5'd13, 32'd3, 32'd5, 32'd0, 1'b0, 5'd9, 2'd0, 2'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    #1;
    repeat (5) step();
    #3;
    rst = 0;
    #1;
    check("async_rst_stall", ex_stall, 1'b0);
    check("async_rst_valid", EX_MEM_valid, 1'b0);
    check("async_rst_result", EX_MEM_alu_result, 32'd0);
    idle();
    step();
    rst = 1;
    step();
    alu("rst_hi_cleared", 5'd11, 32'd0, 32'd0, 32'd0);
    alu("rst_lo_cleared", 5'd12, 32'd0, 32'd0, 32'd0);
    alu("slt_neg", 5'd6, 32'hFFFF_FFFF, 32'd1, 32'd1);
    alu("sra", 5'd10, 32'd4, 32'h8000_0000, 32'hF800_0000);

    repeat (3) step();
    check("scoreboard_drained", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog");
  end
endmodule
